pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 11 +
 rtl/hazard_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between ID sources and EX destination
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_rd_is_load,
  output logic                  o_hazard
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never produces a dependency
  assign w_rd_live = i_rd_is_load && (i_rd != '0);
  assign w_rs1_hit = i_uses_rs1 && (i_rs1 == i_rd);
  assign w_rs2_hit = i_uses_rs2 && (i_rs2 == i_rd);
  assign o_hazard  = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline registers and PC
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic                  o_ifid_en,
  output logic                  o_ifid_clear,
  output logic                  o_idex_en,
  output logic                  o_idex_clear,
  output logic                  o_exmem_en,
  output logic                  o_exmem_clear,
  output logic                  o_memwb_en,
  output logic                  o_memwb_clear,
  output logic                  o_mem_timeout,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_mem_stall;
  logic              w_load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .i_rs1        (i_id_rs1),
    .i_rs2        (i_id_rs2),
    .i_uses_rs1   (i_id_uses_rs1),
    .i_uses_rs2   (i_id_uses_rs2),
    .i_rd         (i_ex_rd),
    .i_rd_is_load (i_ex_mem_read),
    .o_hazard     (w_load_use)
  );

  // The request cycle itself already freezes; MEM_WAIT keeps freezing until ready arrives
  assign w_mem_stall = ((r_state == ST_RUN)      && i_mem_req && !i_mem_ready) ||
                       ((r_state == ST_MEM_WAIT) && !i_mem_ready);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: enter wait on an unready request, leave on the ready cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_mem_req && !i_mem_ready) begin
          w_state_next = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // Output priority mux: reset, memory freeze, taken branch, load-use, normal advance
  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_clear  = 1'b0;
    o_idex_en     = 1'b1;
    o_idex_clear  = 1'b0;
    o_exmem_en    = 1'b1;
    o_exmem_clear = 1'b0;
    o_memwb_en    = 1'b1;
    o_memwb_clear = 1'b0;
    if (i_rst) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_ifid_clear  = 1'b1;
      o_idex_en     = 1'b0;
      o_idex_clear  = 1'b1;
      o_exmem_en    = 1'b0;
      o_exmem_clear = 1'b1;
      o_memwb_en    = 1'b0;
      o_memwb_clear = 1'b1;
    end else if (w_mem_stall) begin
      // Everything up to EX/MEM holds; WB receives a bubble so nothing retires twice
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_memwb_clear = 1'b1;
    end else if (i_ex_branch_taken) begin
      // ID and IF hold wrong-path instructions; any load-use on them is moot
      o_ifid_en     = 1'b0;
      o_ifid_clear  = 1'b1;
      o_idex_en     = 1'b0;
      o_idex_clear  = 1'b1;
    end else if (w_load_use) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_idex_clear  = 1'b1;
    end
  end

  // Wait counter only runs while frozen on memory and saturates at the timeout threshold
  always_comb begin
    w_wait_next = '0;
    if (w_mem_stall) begin
      w_wait_next = (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + WAIT_W'(1);
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == WAIT_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (!o_pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_mem_timeout = r_timeout;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int RW  = 5;
  localparam int TO  = 16;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  // register action as seen by a clear-dominant pipeline register
  localparam int ADV  = 0;
  localparam int HOLD = 1;
  localparam int CLR  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1, rs2, rd;
  logic          u1, u2, mr, br, req, rdy;
  logic          pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic          exmem_en, exmem_clr, memwb_en, memwb_clr, tmo;
  logic [CW-1:0] scnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit m_valid = 0;
  bit m_wait  = 0;
  int m_wcnt  = 0;
  bit m_to    = 0;
  int m_sc    = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_id_rs1          (rs1),
    .i_id_rs2          (rs2),
    .i_id_uses_rs1     (u1),
    .i_id_uses_rs2     (u2),
    .i_ex_rd           (rd),
    .i_ex_mem_read     (mr),
    .i_ex_branch_taken (br),
    .i_mem_req         (req),
    .i_mem_ready       (rdy),
    .o_pc_en           (pc_en),
    .o_ifid_en         (ifid_en),
    .o_ifid_clear      (ifid_clr),
    .o_idex_en         (idex_en),
    .o_idex_clear      (idex_clr),
    .o_exmem_en        (exmem_en),
    .o_exmem_clear     (exmem_clr),
    .o_memwb_en        (memwb_en),
    .o_memwb_clear     (memwb_clr),
    .o_mem_timeout     (tmo),
    .o_stall_cnt       (scnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int action(input logic en, input logic clr);
    if (clr) return CLR;
    if (en) return HOLD - 1;
    return HOLD;
  endfunction

  // per-cycle compare against the behavioural model, then advance the model
  always @(negedge clk) begin
    bit stall, lu, pc;
    int a_if, a_ie, a_em, a_mw;
    lu    = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    stall = m_wait ? !rdy : (req && !rdy);
    if (rst) begin
      pc = 0; a_if = CLR; a_ie = CLR; a_em = CLR; a_mw = CLR;
    end else if (stall) begin
      pc = 0; a_if = HOLD; a_ie = HOLD; a_em = HOLD; a_mw = CLR;
    end else if (br) begin
      pc = 1; a_if = CLR; a_ie = CLR; a_em = ADV; a_mw = ADV;
    end else if (lu) begin
      pc = 0; a_if = HOLD; a_ie = CLR; a_em = ADV; a_mw = ADV;
    end else begin
      pc = 1; a_if = ADV; a_ie = ADV; a_em = ADV; a_mw = ADV;
    end
    chk("pc_en", int'(pc_en), int'(pc));
    chk("ifid_act", action(ifid_en, ifid_clr), a_if);
    chk("idex_act", action(idex_en, idex_clr), a_ie);
    chk("exmem_act", action(exmem_en, exmem_clr), a_em);
    chk("memwb_act", action(memwb_en, memwb_clr), a_mw);
    if (m_valid) begin
      chk("mem_timeout", int'(tmo), int'(m_to));
      chk("stall_cnt", int'(scnt), m_sc);
    end
    if (rst) begin
      m_valid = 1; m_wait = 0; m_wcnt = 0; m_to = 0; m_sc = 0;
    end else begin
      m_wcnt = stall ? ((m_wcnt + 1 > TO) ? TO : m_wcnt + 1) : 0;
      if (m_wcnt == TO) m_to = 1;
      m_wait = stall;
      if (!pc && m_sc < SAT) m_sc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    mr = 0; br = 0; req = 0; rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    chk("rst_pc_en", int'(pc_en), 0);
    chk("rst_ifid_clear", int'(ifid_clr), 1);
    chk("rst_memwb_clear", int'(memwb_clr), 1);
    tick();
    idle();
    @(negedge clk);
    chk("reset_stall_cnt", int'(scnt), 0);
    chk("reset_timeout", int'(tmo), 0);
    chk("idle_pc_en", int'(pc_en), 1);

    // load-use: EX load rd=5, ID reads rs1=5
    tick();
    mr = 1; rd = 5; rs1 = 5; u1 = 1;
    @(negedge clk);
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_ifid_en", int'(ifid_en), 0);
    chk("lu_idex_clear", int'(idex_clr), 1);
    tick();
    mr = 0; rd = 7;
    @(negedge clk);
    chk("lu_after_pc_en", int'(pc_en), 1);
    chk("lu_stall_cnt", int'(scnt), 1);

    // load into x0 never stalls; rs2 path stalls
    tick();
    mr = 1; rd = 0; rs1 = 0; u1 = 1;
    @(negedge clk);
    chk("lu_x0_pc_en", int'(pc_en), 1);
    tick();
    u1 = 0; rd = 9; rs2 = 9; u2 = 1;
    @(negedge clk);
    chk("lu_rs2_pc_en", int'(pc_en), 0);

    // taken branch overrides load-use
    tick();
    br = 1;
    @(negedge clk);
    chk("br_pc_en", int'(pc_en), 1);
    chk("br_ifid_clear", int'(ifid_clr), 1);
    chk("br_idex_clear", int'(idex_clr), 1);
    tick();
    idle();
    @(negedge clk);
    chk("br_stall_cnt", int'(scnt), 2);

    // memory wait: 3 not-ready cycles, then ready
    do_reset();
    idle();
    req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mw_memwb_clear", int'(memwb_clr), 1);
      chk("mw_pc_en", int'(pc_en), 0);
      tick();
    end
    rdy = 1;
    @(negedge clk);
    chk("mw_release_pc_en", int'(pc_en), 1);
    tick();
    req = 0; rdy = 0;
    @(negedge clk);
    chk("mw_run_pc_en", int'(pc_en), 1);
    chk("mw_stall_cnt", int'(scnt), 3);

    // req with ready in the same cycle
    tick();
    req = 1; rdy = 1;
    @(negedge clk);
    chk("mw_hit_pc_en", int'(pc_en), 1);
    tick();
    req = 0; rdy = 0;

    // timeout: ready low for 20 cycles, flag from cycle 16 of the wait
    do_reset();
    idle();
    req = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("to_flag", int'(tmo), (k >= TO) ? 1 : 0);
      tick();
    end
    rdy = 1;
    tick();
    idle();
    @(negedge clk);
    chk("to_sticky", int'(tmo), 1);
    chk("sat_stall_cnt", int'(scnt), SAT);
    tick();
    tick();
    @(negedge clk);
    chk("to_sticky_late", int'(tmo), 1);

    // reset in the middle of MEM_WAIT
    tick();
    req = 1;
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("rmid_ifid_clear", int'(ifid_clr), 1);
    chk("rmid_exmem_clear", int'(exmem_clr), 1);
    chk("rmid_pc_en", int'(pc_en), 0);
    tick();
    idle();
    @(negedge clk);
    chk("rmid_run_pc_en", int'(pc_en), 1);
    chk("rmid_timeout", int'(tmo), 0);
    chk("rmid_stall_cnt", int'(scnt), 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
